// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// Micro-program sequencer that sits in front of the microcode EPROM.
// It owns the micro-PC, drives the EPROM address and the active-low
// chip-select/output-enable pins, and captures each 64-bit microword into
// a pipeline register for the datapath. Every microinstruction takes two
// clocks: FETCH reads the EPROM, and EXEC executes the captured word and
// resolves the next micro-address.
// Sequencing operations: NEXT, JUMP, conditional BRANCH, CALL/RET on a
// small return stack, opcode DISPATCH (which may stall in DWAIT), and HALT.
//
// Optional feature macro: MC_PARITY_EN
//   defined   : the captured microword must have odd parity over bits
//               [63:0]. On a parity error the word is not executed, the
//               sticky par_err is set and the sequencer halts.
//   undefined : par_err is tied low and bit 63 is passed through
//               uninterpreted.

module microcode_sequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       WORD_W      = 64,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        opcode,
    input  logic              opcode_valid,
    input  logic [3:0]        cond,
    input  logic [WORD_W-1:0] mc_data,
    output logic [ADDR_W-1:0] mc_addr,
    output logic              _cs,
    output logic              _oe,
    output logic [WORD_W-1:0] uword,
    output logic              uword_valid,
    output logic              opcode_ack,
    output logic              halted,
    output logic              stack_err,
    output logic              par_err
);

    // Stack pointer counts occupied entries (0..STACK_DEPTH).
    // The entry index is one bit narrower when the depth is a power of two.
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_BRANCH   = 3'd2,
        OP_CALL     = 3'd3,
        OP_RET      = 3'd4,
        OP_DISPATCH = 3'd5,
        OP_HALT     = 3'd6,
        OP_RSVD     = 3'd7
    } seq_op_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [WORD_W-1:0] uword_q, uword_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              stack_err_q, stack_err_d;

    // Fields of the captured microword.
    seq_op_e           seq_op;
    logic [ADDR_W-1:0] target;
    logic [1:0]        cond_sel;
    logic              cond_hit;

    // Derived helpers.
    logic [ADDR_W-1:0] upc_inc;
    logic [SP_W-1:0]   sp_pop;
    logic              stack_full;
    logic              stack_empty;
    logic              par_fail;
    logic              ack_c;

    assign seq_op   = seq_op_e'(uword_q[10:8]);
    assign target   = ADDR_W'(uword_q[7:0]);
    assign cond_sel = uword_q[12:11];
    assign cond_hit = cond[cond_sel];

    // The increment wraps naturally modulo 2^ADDR_W, so 8'hFF+1 gives 8'h00
    // for both the sequential path and the pushed return address.
    assign upc_inc     = upc_q + ADDR_W'(1);
    assign sp_pop      = sp_q - SP_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

`ifdef MC_PARITY_EN
    logic par_err_q, par_err_d;

    // An EXEC word with even parity is treated as corrupt.
    assign par_fail = (state_q == EXEC) && !(^uword_q[63:0]);
    assign par_err  = par_err_q;
`else
    assign par_fail = 1'b0;
    assign par_err  = 1'b0;
`endif

    // Next-state logic: resolve sequencing, stack updates and error capture.
    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        uword_d     = uword_q;
        sp_d        = sp_q;
        stack_d     = stack_q;
        stack_err_d = stack_err_q;
        ack_c       = 1'b0;
`ifdef MC_PARITY_EN
        par_err_d   = par_err_q;
`endif

        case (state_q)
            FETCH: begin
                uword_d = mc_data;
                state_d = EXEC;
            end

            EXEC: begin
                if (par_fail) begin
`ifdef MC_PARITY_EN
                    par_err_d = 1'b1;
`endif
                    state_d   = HALT;
                end else begin
                    state_d = FETCH;
                    case (seq_op)
                        OP_JUMP: begin
                            upc_d = target;
                        end
                        OP_BRANCH: begin
                            upc_d = cond_hit ? target : upc_inc;
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                stack_err_d = 1'b1;
                                state_d     = HALT;
                            end else begin
                                stack_d[sp_q[IDX_W-1:0]] = upc_inc;
                                sp_d  = sp_q + SP_W'(1);
                                upc_d = target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                stack_err_d = 1'b1;
                                state_d     = HALT;
                            end else begin
                                upc_d = stack_q[sp_pop[IDX_W-1:0]];
                                sp_d  = sp_pop;
                            end
                        end
                        OP_DISPATCH: begin
                            if (opcode_valid) begin
                                upc_d = ADDR_W'(opcode);
                                ack_c = 1'b1;
                            end else begin
                                state_d = DWAIT;
                            end
                        end
                        OP_HALT: begin
                            state_d = HALT;
                        end
                        default: begin
                            upc_d = upc_inc;
                        end
                    endcase
                end
            end

            DWAIT: begin
                if (opcode_valid) begin
                    upc_d   = ADDR_W'(opcode);
                    ack_c   = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = HALT;
            end
        endcase
    end

    // State registers; the async reset returns everything to the reset vector with an empty stack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            upc_q       <= RESET_VEC;
            uword_q     <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
`ifdef MC_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            uword_q     <= uword_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            stack_q     <= stack_d;
`ifdef MC_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // EPROM strobes and status decode; reset forces the EPROM off even though state reads FETCH.
    always_comb begin
        _cs         = reset || !((state_q == FETCH) || (state_q == EXEC));
        _oe         = reset || (state_q != FETCH);
        uword_valid = !reset && (state_q == EXEC) && !par_fail;
        opcode_ack  = !reset && ack_c;
        halted      = (state_q == HALT);
    end

    assign mc_addr   = upc_q;
    assign uword     = uword_q;
    assign stack_err = stack_err_q;

endmodule
